// File: rtl/volt_uart_framer.sv
`default_nettype none
// ============================================================================
//  Module      : volt_uart_framer
//  Description : Packs two 12-bit ADC voltage results and their sign bits
//                into a fixed-length byte frame. Once per frame period it
//                hands the frame to uart_tx, one byte per byte-time.
//                Optional build macro: VOLT_FRAME_CKSUM_EN appends a
//                checksum byte, giving 6-byte frames instead of 5.
//  Revision    : 1.0 - initial release
// ============================================================================
module volt_uart_framer #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int UART_BPS  = 9600,
  parameter int BYTE_CYC  = (CLK_FREQ / UART_BPS) * 11,
  parameter int FRAME_CYC = 5_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        en,
  input  logic [11:0] volt_ch1,
  input  logic        volt_sign_ch1,
  input  logic [11:0] volt_ch2,
  input  logic        volt_sign_ch2,
  output logic [7:0]  pi_data,
  output logic        pi_flag,
  output logic        busy,
  output logic [7:0]  ovr_cnt
);

`ifdef VOLT_FRAME_CKSUM_EN
  localparam logic [2:0] C_LAST_IDX = 3'd5;
`else
  localparam logic [2:0] C_LAST_IDX = 3'd4;
`endif

  localparam int PCW = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam int GCW = (BYTE_CYC > 2) ? $clog2(BYTE_CYC) : 1;

  // Last value of the free-running period counter.
  localparam logic [PCW-1:0] C_PERIOD_LAST = PCW'(FRAME_CYC - 1);
  // The gap lasts BYTE_CYC-1 cycles; together with the SEND cycle this
  // spaces pi_flag pulses exactly BYTE_CYC apart.
  localparam logic [GCW-1:0] C_GAP_LAST    = GCW'(BYTE_CYC - 2);
  localparam logic [7:0]     C_HEADER      = 8'hA5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [PCW-1:0] r_per_cnt;
  logic [GCW-1:0] r_gap_cnt;
  logic [2:0]     r_byte_idx;
  logic [11:0]    r_snap_ch1;
  logic [11:0]    r_snap_ch2;
  logic           r_snap_sg1;
  logic           r_snap_sg2;

  logic           w_tick;
  logic           w_start;
  logic           w_ovr;
  logic           w_gap_done;
  logic [7:0]     w_b1;
  logic [7:0]     w_b2;
  logic [7:0]     w_b3;
  logic [7:0]     w_b4;
  logic [7:0]     w_byte;

  assign w_tick     = (r_per_cnt == C_PERIOD_LAST);
  assign w_gap_done = (r_gap_cnt == C_GAP_LAST);
  // A tick that finds a frame still in flight is dropped and counted.
  assign w_ovr      = w_tick && en && (r_state != S_IDLE);

  // Frame payload is built only from the snapshot so it cannot tear.
  assign w_b1 = {r_snap_sg1, 3'b000, r_snap_ch1[11:8]};
  assign w_b2 = r_snap_ch1[7:0];
  assign w_b3 = {r_snap_sg2, 3'b000, r_snap_ch2[11:8]};
  assign w_b4 = r_snap_ch2[7:0];

`ifdef VOLT_FRAME_CKSUM_EN
  logic [7:0] w_cksum;
  assign w_cksum = w_b1 + w_b2 + w_b3 + w_b4;
`endif

  // Select the frame byte addressed by the current byte index.
  always_comb begin
    w_byte = 8'h00;
    case (r_byte_idx)
      3'd0:    w_byte = C_HEADER;
      3'd1:    w_byte = w_b1;
      3'd2:    w_byte = w_b2;
      3'd3:    w_byte = w_b3;
      3'd4:    w_byte = w_b4;
`ifdef VOLT_FRAME_CKSUM_EN
      3'd5:    w_byte = w_cksum;
`endif
      default: w_byte = 8'h00;
    endcase
  end

  // Free-running frame period counter, independent of en.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_per_cnt <= '0;
    end else if (w_tick) begin
      r_per_cnt <= '0;
    end else begin
      r_per_cnt <= r_per_cnt + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic: start on tick, alternate SEND/GAP per byte.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick && en) begin
          w_start     = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (w_gap_done) begin
          w_state_nxt = (r_byte_idx == C_LAST_IDX) ? S_IDLE : S_SEND;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture the four inputs at frame start.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_snap_ch1 <= '0;
      r_snap_ch2 <= '0;
      r_snap_sg1 <= 1'b0;
      r_snap_sg2 <= 1'b0;
    end else if (w_start) begin
      r_snap_ch1 <= volt_ch1;
      r_snap_ch2 <= volt_ch2;
      r_snap_sg1 <= volt_sign_ch1;
      r_snap_sg2 <= volt_sign_ch2;
    end
  end

  // Byte index and inter-byte gap counter.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_byte_idx <= '0;
      r_gap_cnt  <= '0;
    end else begin
      if (w_start) begin
        r_byte_idx <= '0;
      end else if ((r_state == S_GAP) && w_gap_done && (r_byte_idx != C_LAST_IDX)) begin
        r_byte_idx <= r_byte_idx + 3'd1;
      end
      if (r_state == S_SEND) begin
        r_gap_cnt <= '0;
      end else if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end
    end
  end

  // Registered UART handoff: one-cycle strobe, data held until next byte.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pi_flag <= 1'b0;
      pi_data <= 8'h00;
    end else begin
      pi_flag <= (r_state == S_SEND);
      if (r_state == S_SEND) begin
        pi_data <= w_byte;
      end
    end
  end

  // busy rises the cycle after the start tick and falls one cycle after
  // the FSM has returned to IDLE, covering the whole final byte-time.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      busy <= 1'b0;
    end else begin
      busy <= (w_state_nxt != S_IDLE) || (r_state != S_IDLE);
    end
  end

  // Saturating count of dropped frame ticks.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovr_cnt <= 8'h00;
    end else if (w_ovr && (ovr_cnt != 8'hFF)) begin
      ovr_cnt <= ovr_cnt + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_volt_uart_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_volt_uart_framer
//  Description : Self-checking bench for volt_uart_framer. Two instances
//                share stimulus: one with the nominal frame period, one with
//                a short period so that frame ticks collide with frames in
//                flight. Both are compared every cycle with a cycle-count
//                reference model. Honours VOLT_FRAME_CKSUM_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_volt_uart_framer;

  localparam int C_CLKF = 1000;
  localparam int C_BPS  = 100;
  localparam int C_BC   = 110;
  localparam int C_FC0  = 1000;
  localparam int C_FC1  = 50;
`ifdef VOLT_FRAME_CKSUM_EN
  localparam int C_NB = 6;
`else
  localparam int C_NB = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] ch1 = '0;
  logic        sg1 = 1'b0;
  logic [11:0] ch2 = '0;
  logic        sg2 = 1'b0;
  logic [7:0]  pd [2];
  logic        pf [2];
  logic        bz [2];
  logic [7:0]  oc [2];

  always #5 clk = ~clk;

  volt_uart_framer #(
    .CLK_FREQ(C_CLKF), .UART_BPS(C_BPS), .BYTE_CYC(C_BC), .FRAME_CYC(C_FC0)
  ) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .en(en),
    .volt_ch1(ch1), .volt_sign_ch1(sg1), .volt_ch2(ch2), .volt_sign_ch2(sg2),
    .pi_data(pd[0]), .pi_flag(pf[0]), .busy(bz[0]), .ovr_cnt(oc[0])
  );

  volt_uart_framer #(
    .CLK_FREQ(C_CLKF), .UART_BPS(C_BPS), .BYTE_CYC(C_BC), .FRAME_CYC(C_FC1)
  ) dut_ovr (
    .sys_clk(clk), .sys_rst_n(rst_n), .en(en),
    .volt_ch1(ch1), .volt_sign_ch1(sg1), .volt_ch2(ch2), .volt_sign_ch2(sg2),
    .pi_data(pd[1]), .pi_flag(pf[1]), .busy(bz[1]), .ovr_cnt(oc[1])
  );

  // Stimulus requested for the next cycle.
  logic        s_en;
  logic [11:0] s_ch1;
  logic        s_sg1;
  logic [11:0] s_ch2;
  logic        s_sg2;

  // Reference model state.
  int          cyc;
  bit          fv [2];
  int          fs [2];
  logic [7:0]  fb [2][6];
  int          m_ovr [2];
  logic [7:0]  m_last [2];

  // Byte log of the nominal instance.
  logic [7:0]  q_b [$];
  int          q_c [$];
  int          fall_c;
  logic        prev_bz;

  int          n_chk;
  int          n_fail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int frame_len(input int i);
    return (i == 0) ? C_FC0 : C_FC1;
  endfunction

  // Frame byte k from plain arithmetic on the captured values.
  function automatic logic [7:0] frame_byte(input int k, input int c1, input int g1,
                                            input int c2, input int g2);
    int b [6];
    b[0] = 165;
    b[1] = g1 * 128 + c1 / 256;
    b[2] = c1 % 256;
    b[3] = g2 * 128 + c2 / 256;
    b[4] = c2 % 256;
    b[5] = (b[1] + b[2] + b[3] + b[4]) % 256;
    return 8'(b[k]);
  endfunction

  function automatic logic [7:0] qget(input int k);
    if (k < q_b.size()) return q_b[k];
    return 8'hxx;
  endfunction

  function automatic int qcget(input int k);
    if (k < q_c.size()) return q_c[k];
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      fv[i]     = 1'b0;
      fs[i]     = 0;
      m_ovr[i]  = 0;
      m_last[i] = 8'h00;
    end
  endtask

  // Expected outputs in the current cycle, from frame start times.
  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      logic eflag;
      logic ebusy;
      int   d;
      eflag = 1'b0;
      ebusy = 1'b0;
      if (fv[i]) begin
        d = cyc - fs[i] - 2;
        if (d >= 0 && (d % C_BC) == 0 && (d / C_BC) < C_NB) begin
          eflag     = 1'b1;
          m_last[i] = fb[i][d / C_BC];
        end
        ebusy = (cyc >= fs[i] + 1) && (cyc <= fs[i] + 1 + C_NB * C_BC);
      end
      check_eq($sformatf("flag%0d", i), 32'(pf[i]), 32'(eflag));
      check_eq($sformatf("data%0d", i), 32'(pd[i]), 32'(m_last[i]));
      check_eq($sformatf("busy%0d", i), 32'(bz[i]), 32'(ebusy));
      check_eq($sformatf("ovr%0d", i),  32'(oc[i]), 32'(m_ovr[i]));
    end
  endtask

  // Decisions taken at the end of the current cycle with its inputs.
  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      int f;
      f = frame_len(i);
      if ((cyc % f) == f - 1 && s_en) begin
        if (!fv[i] || cyc >= fs[i] + 1 + C_NB * C_BC) begin
          fv[i] = 1'b1;
          fs[i] = cyc;
          for (int k = 0; k < 6; k++)
            fb[i][k] = frame_byte(k, int'(s_ch1), int'(s_sg1), int'(s_ch2), int'(s_sg2));
        end else if (m_ovr[i] < 255) begin
          m_ovr[i]++;
        end
      end
    end
  endtask

  task automatic apply_stim();
    en  = s_en;
    ch1 = s_ch1;
    sg1 = s_sg1;
    ch2 = s_ch2;
    sg2 = s_sg2;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    if (pf[0]) begin
      q_b.push_back(pd[0]);
      q_c.push_back(cyc);
    end
    if (prev_bz && !bz[0]) fall_c = cyc;
    prev_bz = bz[0];
    apply_stim();
    model_update();
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  // Assert reset now, check outputs clear at once, release on a negedge.
  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("rst_data%0d", i), 32'(pd[i]), 32'h0);
      check_eq($sformatf("rst_flag%0d", i), 32'(pf[i]), 32'h0);
      check_eq($sformatf("rst_busy%0d", i), 32'(bz[i]), 32'h0);
      check_eq($sformatf("rst_ovr%0d", i),  32'(oc[i]), 32'h0);
    end
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    prev_bz = 1'b0;
    cyc = 0;
    apply_stim();
    model_update();
    cyc = 1;
  endtask

  task automatic set_basic();
    s_ch1 = 12'hABC;
    s_sg1 = 1'b1;
    s_ch2 = 12'h123;
    s_sg2 = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_basic [6];
    int         ovr_keep;
    exp_basic = '{8'hA5, 8'h8A, 8'hBC, 8'h01, 8'h23, 8'h6A};
    n_chk  = 0;
    n_fail = 0;
    fall_c = -1;
    prev_bz = 1'b0;
    cyc = 0;
    s_en = 1'b1;
    set_basic();
    apply_stim();
    repeat (3) @(negedge clk);
    do_reset(2);

    // Basic frame, plus the first overrun on the short-period instance.
    run_to(100);
    check_eq("ovr_pre", 32'(oc[1]), 32'd0);
    run_to(101);
    check_eq("ovr_first", 32'(oc[1]), 32'd1);
    run_to(1700);
    check_eq("basic_nbytes", 32'(q_b.size()), 32'(C_NB));
    for (int k = 0; k < C_NB; k++)
      check_eq($sformatf("basic_b%0d", k), 32'(qget(k)), 32'(exp_basic[k]));
    check_eq("basic_first_lat", 32'(qcget(0)), 32'd1001);
    for (int k = 1; k < C_NB; k++)
      check_eq($sformatf("basic_gap%0d", k), 32'(qcget(k) - qcget(k - 1)), 32'(C_BC));
    check_eq("basic_busy_fall", 32'(fall_c - qcget(C_NB - 1)), 32'(C_BC));

    // Snapshot integrity: ch1 cleared one cycle after the tick.
    q_b.delete();
    q_c.delete();
    run_to(2000);
    s_ch1 = 12'h000;
    run_to(2700);
    check_eq("snap_b1", 32'(qget(1)), 32'h8A);
    check_eq("snap_b2", 32'(qget(2)), 32'hBC);

    // Randomised values and enable, checked against the model each cycle.
    while (cyc < 9000) begin
      if ((cyc % 1000) == 500) s_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        s_ch1 = 12'($urandom);
        s_ch2 = 12'($urandom);
        s_sg1 = 1'($urandom);
        s_sg2 = 1'($urandom);
      end
      step();
    end

    // en dropped after byte 2: frame completes, no new frame, no overrun.
    run_to(9500);
    s_en = 1'b1;
    q_b.delete();
    q_c.delete();
    ovr_keep = int'(oc[0]);
    run_to(10230);
    s_en = 1'b0;
    run_to(11400);
    check_eq("endrop_nbytes", 32'(q_b.size()), 32'(C_NB));
    check_eq("endrop_ovr", 32'(oc[0]), 32'(ovr_keep));
    check_eq("endrop_idle", 32'(bz[0]), 32'h0);

    // Reset between bytes 3 and 4; restart only at the next period tick.
    s_en = 1'b1;
    set_basic();
    run_to(12380);
    do_reset(4);
    q_b.delete();
    q_c.delete();
    run_to(1100);
    check_eq("rst_next_b0", 32'(qget(0)), 32'hA5);
    check_eq("rst_next_lat", 32'(qcget(0)), 32'd1001);

    // Sustained overruns on the short-period instance must saturate.
    run_to(17500);
    check_eq("ovr_sat", 32'(oc[1]), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
